// File: rtl/alu_4_pkg.sv
// alu_4_pkg: shared width and opcode constants for the 4-bit ALU
package alu_4_pkg;
    localparam int WIDTH = 4;
    localparam logic [2:0] OP_TRANSFER = 3'b000;
    localparam logic [2:0] OP_ADD      = 3'b001;
    localparam logic [2:0] OP_SUBB     = 3'b010;
    localparam logic [2:0] OP_DEC      = 3'b011;
    localparam logic [2:0] OP_AND      = 3'b100;
    localparam logic [2:0] OP_OR       = 3'b101;
    localparam logic [2:0] OP_XOR      = 3'b110;
    localparam logic [2:0] OP_NOT      = 3'b111;
endpackage

// File: rtl/alu_4_arith.sv
// alu_4_arith: B-operand mux feeding a ripple-carry adder with carry and overflow outputs
module alu_4_arith
    import alu_4_pkg::*;
(
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_op,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_v
);
    logic [WIDTH-1:0] b_mux;
    logic [WIDTH:0]   c;
    // Second adder operand: 0000 / B / ~B / 1111 chosen by the low opcode bits
    always_comb b_mux = ({1'b0, i_op} == OP_TRANSFER) ? '0 :
                        ({1'b0, i_op} == OP_ADD)      ? i_b :
                        ({1'b0, i_op} == OP_SUBB)     ? ~i_b :
                        ({1'b0, i_op} == OP_DEC)      ? '1 : '0;
    assign c[0] = i_cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign o_sum[i] = i_a[i] ^ b_mux[i] ^ c[i];
        assign c[i+1]   = (i_a[i] & b_mux[i]) | (c[i] & (i_a[i] ^ b_mux[i]));
    end
    assign o_cout = c[WIDTH];
    assign o_v    = c[WIDTH] ^ c[WIDTH-1];
endmodule

// File: rtl/alu_4.sv
// alu_4: registered 4-bit ALU with arithmetic/logic ops, carry, zero and overflow flags
module alu_4
    import alu_4_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_sel,
    input  logic             i_Cin,
    output logic [WIDTH-1:0] o_G,
    output logic             o_Cout,
    output logic             o_Z,
    output logic             o_V
);
    logic [WIDTH-1:0] sum, logic_res, g_d, g_q;
    logic             a_cout, a_v, cout_d, cout_q, z_d, z_q, v_d, v_q;

    alu_4_arith u_arith (
        .i_a    (i_a),
        .i_b    (i_b),
        .i_op   (i_sel[1:0]),
        .i_cin  (i_Cin),
        .o_sum  (sum),
        .o_cout (a_cout),
        .o_v    (a_v)
    );

    // Bitwise logic unit
    always_comb logic_res = (i_sel == OP_AND) ? i_a & i_b :
                            (i_sel == OP_OR)  ? i_a | i_b :
                            (i_sel == OP_XOR) ? i_a ^ i_b :
                            (i_sel == OP_NOT) ? ~i_a : '0;

    // Result mux and flags; logic ops force carry/overflow low, disabled cycles hold
    always_comb begin
        g_d    = g_q;
        cout_d = cout_q;
        v_d    = v_q;
        z_d    = z_q;
        if (i_en) begin
            g_d    = i_sel[2] ? logic_res : sum;
            cout_d = ~i_sel[2] & a_cout;
            v_d    = ~i_sel[2] & a_v;
            z_d    = (g_d == '0);
        end
    end

    // Output registers; reset wins over enable
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            g_q    <= '0;
            cout_q <= 1'b0;
            z_q    <= 1'b0;
            v_q    <= 1'b0;
        end else begin
            g_q    <= g_d;
            cout_q <= cout_d;
            z_q    <= z_d;
            v_q    <= v_d;
        end
    end

    assign o_G    = g_q;
    assign o_Cout = cout_q;
    assign o_Z    = z_q;
    assign o_V    = v_q;
endmodule

// File: tb/tb_alu_4.sv
// tb_alu_4: random and directed checks of alu_4 against an arithmetic reference model
module tb_alu_4;
    logic       i_clk = 1'b0;
    logic       i_rst_n, i_en, i_Cin;
    logic [3:0] i_a, i_b, o_G;
    logic [2:0] i_sel;
    logic       o_Cout, o_Z, o_V;
    int         checks = 0;
    int         errors = 0;
    logic [6:0] m_out = '0;
    logic       live = 1'b0;

    always #5 i_clk = ~i_clk;

    alu_4 dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_sel   (i_sel),
        .i_Cin   (i_Cin),
        .o_G     (o_G),
        .o_Cout  (o_Cout),
        .o_Z     (o_Z),
        .o_V     (o_V)
    );

    // Returns {G, Cout, Z, V} from plain integer arithmetic and signed range checks
    function automatic logic [6:0] ref_op(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] s, input logic cin);
        int bv, sum, sa, sb, ss;
        logic [3:0] g;
        logic c, v;
        if (s[2]) begin
            g = (s == 3'd4) ? (a & b) : (s == 3'd5) ? (a | b) : (s == 3'd6) ? (a ^ b) : ~a;
            c = 1'b0;
            v = 1'b0;
        end else begin
            bv  = (s == 3'd0) ? 0 : (s == 3'd1) ? int'(b) : (s == 3'd2) ? 15 - int'(b) : 15;
            sum = int'(a) + bv + int'(cin);
            g   = sum[3:0];
            c   = (sum >= 16);
            sa  = (a >= 4'd8) ? int'(a) - 16 : int'(a);
            sb  = (bv >= 8) ? bv - 16 : bv;
            ss  = sa + sb + int'(cin);
            v   = (ss > 7) || (ss < -8);
        end
        return {g, c, (g == 4'd0), v};
    endfunction

    always @(posedge i_clk) begin
        if (!i_rst_n) m_out <= '0;
        else if (i_en) m_out <= ref_op(i_a, i_b, i_sel, i_Cin);
        live <= 1'b1;
    end

    always @(negedge i_clk) begin
        if (live) begin
            checks++;
            if ({o_G, o_Cout, o_Z, o_V} !== m_out) begin
                errors++;
                $display("FAIL model t=%0t got G/C/Z/V=%b required %b", $time,
                         {o_G, o_Cout, o_Z, o_V}, m_out);
            end
        end
    end

    task automatic drive(input logic rst_n, input logic en, input logic [3:0] a,
                         input logic [3:0] b, input logic [2:0] s, input logic cin);
        i_rst_n = rst_n;
        i_en    = en;
        i_a     = a;
        i_b     = b;
        i_sel   = s;
        i_Cin   = cin;
        @(negedge i_clk);
    endtask

    task automatic chk(input string name, input logic [6:0] exp);
        checks++;
        if ({o_G, o_Cout, o_Z, o_V} !== exp) begin
            errors++;
            $display("FAIL %s got G/C/Z/V=%b required %b", name, {o_G, o_Cout, o_Z, o_V}, exp);
        end
    endtask

    initial begin
        drive(1'b0, 1'b1, 4'hf, 4'h1, 3'd1, 1'b1);
        chk("reset", 7'b0000_0_0_0);
        drive(1'b1, 1'b1, 4'hf, 4'h1, 3'd0, 1'b0); chk("s000 c0", 7'b1111_0_0_0);
        drive(1'b1, 1'b1, 4'hf, 4'h1, 3'd0, 1'b1); chk("s000 c1", 7'b0000_1_1_0);
        drive(1'b1, 1'b1, 4'hf, 4'h1, 3'd1, 1'b0); chk("s001 c0", 7'b0000_1_1_0);
        drive(1'b1, 1'b1, 4'hf, 4'h1, 3'd1, 1'b1); chk("s001 c1", 7'b0001_1_0_0);
        drive(1'b1, 1'b1, 4'hf, 4'h1, 3'd2, 1'b0); chk("s010 c0", 7'b1101_1_0_0);
        drive(1'b1, 1'b1, 4'hf, 4'h1, 3'd2, 1'b1); chk("s010 c1", 7'b1110_1_0_0);
        drive(1'b1, 1'b1, 4'hf, 4'h1, 3'd3, 1'b0); chk("s011 c0", 7'b1110_1_0_0);
        drive(1'b1, 1'b1, 4'hf, 4'h1, 3'd3, 1'b1); chk("s011 c1", 7'b1111_1_0_0);
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b1, 4'hf, 4'h1, 3'd4, c[0]); chk("and", 7'b0001_0_0_0);
            drive(1'b1, 1'b1, 4'hf, 4'h1, 3'd5, c[0]); chk("or",  7'b1111_0_0_0);
            drive(1'b1, 1'b1, 4'hf, 4'h1, 3'd6, c[0]); chk("xor", 7'b1110_0_0_0);
            drive(1'b1, 1'b1, 4'hf, 4'h1, 3'd7, c[0]); chk("not", 7'b0000_0_1_0);
        end
        drive(1'b1, 1'b1, 4'h7, 4'h1, 3'd1, 1'b0); chk("overflow", 7'b1000_0_0_1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 4'(k + 2), 4'h9, 3'(k + 4), 1'b1);
            chk("enable hold", 7'b1000_0_0_1);
        end
        drive(1'b0, 1'b1, 4'h3, 4'h4, 3'd1, 1'b0); chk("mid reset", 7'b0000_0_0_0);
        drive(1'b1, 1'b0, 4'h3, 4'h4, 3'd1, 1'b0); chk("post reset idle", 7'b0000_0_0_0);
        drive(1'b1, 1'b1, 4'h3, 4'h4, 3'd1, 1'b0); chk("first capture", 7'b0111_0_0_0);
        for (int n = 0; n < 400; n++)
            drive(1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 3) != 0),
                  4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_4.md
ALU_4 -- requirements
Module: alu_4

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port i_en, input, 1 bit: capture enable; outputs update only when high.
REQ-004 SHALL have port i_a, input, 4 bits: operand A, unsigned / two's complement.
REQ-005 SHALL have port i_b, input, 4 bits: operand B.
REQ-006 SHALL have port i_sel, input, 3 bits: operation select S[2:0].
REQ-007 SHALL have port i_Cin, input, 1 bit: carry in, used by arithmetic ops only.
REQ-008 SHALL have port o_G, output, 4 bits: registered result.
REQ-009 SHALL have port o_Cout, output, 1 bit: registered carry out.
REQ-010 SHALL have port o_Z, output, 1 bit: registered zero flag, 1 when the registered o_G is 0000.
REQ-011 SHALL have port o_V, output, 1 bit: registered signed-overflow flag.
REQ-012 SHALL have no parameters; all widths are fixed at 4 bits.

Function
REQ-013 i_sel=000: G = A + Cin (transfer when Cin=0, increment when Cin=1).
REQ-014 i_sel=001: G = A + B + Cin (add; add with carry).
REQ-015 i_sel=010: G = A + ~B + Cin (A-B-1 when Cin=0; A-B when Cin=1).
REQ-016 i_sel=011: G = A + 4'b1111 + Cin (decrement when Cin=0; transfer A when Cin=1).
REQ-017 i_sel=100: G = A AND B.
REQ-018 i_sel=101: G = A OR B.
REQ-019 i_sel=110: G = A XOR B.
REQ-020 i_sel=111: G = NOT A.
REQ-021 Arithmetic ops: 5-bit sum, G = sum[3:0], Cout = sum[4]; wrap-around modulo 16 with no saturation.
REQ-022 Arithmetic ops: V = carry into bit 3 XOR carry out of bit 3.
REQ-023 Logic ops (S2=1): i_Cin is ignored; Cout=0 and V=0.
REQ-024 Z SHALL be computed from the same result that is loaded into o_G.
REQ-025 Latency:
- Combinational result is captured at the rising edge where i_en=1.
- Outputs are valid one cycle after the inputs are presented.
REQ-026 When i_en=0, all outputs SHALL hold their previous values.
REQ-027 No handshake: a new operation may be issued every cycle, giving full throughput.

Reset
REQ-028 When i_rst_n=0 at a rising edge: o_G=0000, o_Cout=0, o_Z=0, o_V=0.
REQ-029 Reset SHALL take priority over i_en.
REQ-030 Reset asserted mid-stream SHALL discard the operation presented in that cycle.
REQ-031 After reset release, the first capture occurs at the next edge with i_en=1.

Structure
REQ-032 A shared package alu_4_pkg SHALL define:
- the 3-bit opcode constants OP_TRANSFER, OP_ADD, OP_SUBB, OP_DEC, OP_AND, OP_OR, OP_XOR, OP_NOT;
- the data-width constant (4).
REQ-033 One sub-module alu_4_arith SHALL implement the arithmetic path:
- B-input mux selecting 0000, B, ~B or 1111;
- 4-bit ripple-carry adder;
- outputs sum, Cout and V.
REQ-034 The logic unit, the result mux and the output registers SHALL reside in alu_4.

Verification (A=1111, B=0001, i_en=1; check one cycle after applying)
REQ-035 Arithmetic ops:
- S=000: Cin=0 -> G=1111, Cout=0. Cin=1 -> G=0000, Cout=1, Z=1.
- S=001: Cin=0 -> G=0000, Cout=1, Z=1, V=0. Cin=1 -> G=0001, Cout=1.
- S=010: Cin=0 -> G=1101, Cout=1. Cin=1 -> G=1110, Cout=1.
- S=011: Cin=0 -> G=1110, Cout=1. Cin=1 -> G=1111, Cout=1.
REQ-036 Logic ops, checked with both Cin values, always Cout=0:
- S=100 -> G=0001.
- S=101 -> G=1111.
- S=110 -> G=1110.
- S=111 -> G=0000, Z=1.
REQ-037 Overflow: A=0111, B=0001, S=001, Cin=0 -> G=1000, V=1, Cout=0.
REQ-038 Enable hold: drop i_en after any op, change the inputs -> outputs unchanged.
REQ-039 Reset: assert i_rst_n=0 mid-sequence -> all outputs 0 at the next edge, even with i_en=1.
